// File: rtl/ad9361_ctrl_regs.sv
// AD9361 control register bank: drives RESETB/ENABLE/TXNRX/EN_AGC/CTRL_IN with a
// self-timed reset pulse and a guarded TX/RX switch sequence, plus registered readback.
module ad9361_ctrl_regs #(
    parameter logic [17:0] BASE          = 18'h0,
    parameter int unsigned RF_CTRL_W     = 4,
    parameter int unsigned RST_PULSE_CYC = 16,
    parameter int unsigned GUARD_CYC     = 8,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 wen,
    input  logic [17:0]          addr,
    input  logic [31:0]          din,
    output logic [31:0]          dout,
    output logic                 ad9361_rstb,
    output logic                 ad9361_en,
    output logic                 ad9361_tx_rx,
    output logic                 ad9361_en_agc,
    output logic [RF_CTRL_W-1:0] rf_ctrl_in
);

    typedef enum logic [1:0] {
        RUN,
        DROP,
        SWAP,
        RESTORE
    } state_t;

    localparam logic [17:0] A_RST    = BASE + 18'h100;
    localparam logic [17:0] A_EN     = BASE + 18'h110;
    localparam logic [17:0] A_TXRX   = BASE + 18'h120;
    localparam logic [17:0] A_AGC    = BASE + 18'h130;
    localparam logic [17:0] A_RF     = BASE + 18'h140;
    localparam logic [17:0] A_STATUS = BASE + 18'h150;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_PULSE_CYC);
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYC);

    logic                 wr_en, rd_en, wr_rst;
    logic                 rst_hold, rst_busy, sw_busy, txrx_mismatch, guard_done;
    logic [CNT_W-1:0]     rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]     gcnt_q, gcnt_d;
    state_t               state_q, state_d;
    logic                 en_req_q, en_req_d;
    logic                 txrx_req_q, txrx_req_d;
    logic                 en_q, en_d;
    logic                 txrx_q, txrx_d;
    logic                 agc_q, agc_d;
    logic                 rstb_q, rstb_d;
    logic [RF_CTRL_W-1:0] rf_q, rf_d;
    logic [31:0]          dout_q, dout_d, rdata;
    logic                 unused_din;

    assign unused_din = ^din;

    assign wr_en  = en & wen;
    assign rd_en  = en & ~wen;
    assign wr_rst = wr_en && (addr == A_RST) && din[0];

    // Reset pulse counter; a write while busy reloads and so extends the pulse.
    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if (wr_rst) begin
            rst_cnt_d = RST_LOAD;
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - ONE;
        end
    end

    // Hold uses the next count so ENABLE drops in the same cycle RESETB falls.
    assign rst_hold      = (rst_cnt_d != '0);
    assign rst_busy      = (rst_cnt_q != '0);
    assign rstb_d        = ~rst_hold;
    assign sw_busy       = (state_q != RUN);
    assign txrx_mismatch = (txrx_req_q != txrx_q);
    assign guard_done    = (gcnt_q <= ONE);

    always_comb begin
        en_req_d   = en_req_q;
        txrx_req_d = txrx_req_q;
        agc_d      = agc_q;
        rf_d       = rf_q;
        if (wr_en) begin
            case (addr)
                A_EN:    en_req_d   = din[0];
                A_TXRX:  txrx_req_d = din[0];
                A_AGC:   agc_d      = din[0];
                A_RF:    rf_d       = din[RF_CTRL_W-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (rst_hold) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (txrx_mismatch && en_q) state_d = DROP;
                DROP:    if (guard_done) state_d = SWAP;
                SWAP:    if (guard_done) state_d = RESTORE;
                RESTORE: state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        en_d   = en_q;
        txrx_d = txrx_q;
        gcnt_d = gcnt_q;
        if (rst_hold) begin
            en_d   = 1'b0;
            txrx_d = txrx_req_q;
            gcnt_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    en_d = en_req_q;
                    if (txrx_mismatch) begin
                        if (en_q) begin
                            en_d   = 1'b0;
                            gcnt_d = GUARD_LOAD;
                        end else begin
                            txrx_d = txrx_req_q;
                        end
                    end
                end
                DROP: begin
                    // Commit to the direction that started the sequence; later
                    // requests are picked up by RUN once the sequence finishes.
                    if (guard_done) begin
                        txrx_d = ~txrx_q;
                        gcnt_d = GUARD_LOAD;
                    end else begin
                        gcnt_d = gcnt_q - ONE;
                    end
                end
                SWAP: begin
                    if (guard_done) gcnt_d = '0;
                    else            gcnt_d = gcnt_q - ONE;
                end
                RESTORE: en_d = en_req_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            A_RST:    rdata = {31'b0, rst_busy};
            A_EN:     rdata = {31'b0, en_req_q};
            A_TXRX:   rdata = {31'b0, txrx_req_q};
            A_AGC:    rdata = {31'b0, agc_q};
            A_RF:     rdata = 32'(rf_q);
            A_STATUS: rdata = {28'b0, txrx_q, en_q, sw_busy, rst_busy};
            default:  rdata = '0;
        endcase
    end

    assign dout_d = rd_en ? rdata : dout_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt_q  <= '0;
            gcnt_q     <= '0;
            en_req_q   <= 1'b0;
            txrx_req_q <= 1'b0;
            en_q       <= 1'b0;
            txrx_q     <= 1'b0;
            agc_q      <= 1'b0;
            rstb_q     <= 1'b1;
            rf_q       <= '0;
            dout_q     <= '0;
        end else begin
            rst_cnt_q  <= rst_cnt_d;
            gcnt_q     <= gcnt_d;
            en_req_q   <= en_req_d;
            txrx_req_q <= txrx_req_d;
            en_q       <= en_d;
            txrx_q     <= txrx_d;
            agc_q      <= agc_d;
            rstb_q     <= rstb_d;
            rf_q       <= rf_d;
            dout_q     <= dout_d;
        end
    end

    assign dout          = dout_q;
    assign ad9361_rstb   = rstb_q;
    assign ad9361_en     = en_q;
    assign ad9361_tx_rx  = txrx_q;
    assign ad9361_en_agc = agc_q;
    assign rf_ctrl_in    = rf_q;

endmodule
